id_ex_stage_g7: RTL and testbench

//  Decode-to-execute pipeline register and operand-select stage, directly upstream of alu_g7.

---
 rtl/id_ex_stage_g7.sv | 120 ++++++++++++
 tb/tb_id_ex_stage_g7.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_g7.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection, feeding operands and opcode to alu_g7.
module id_ex_stage_g7 #(
  parameter int unsigned FWD_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_alu_src,
  input  logic [3:0]  id_alu_control,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [31:0] mem_result,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic [31:0] wb_result,
  output logic        ex_valid,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_store_data,
  output logic [3:0]  ex_alu_control,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        load_use_stall
);

  localparam logic [3:0] ALU_ADD = 4'b0000;

  logic        valid_q;
  logic [4:0]  rs1_q, rs2_q, rd_q;
  logic [31:0] rs1_data_q, rs2_data_q, imm_q;
  logic        alu_src_q;
  logic [3:0]  alu_ctl_q;
  logic        rw_q, mr_q, mw_q;
  logic        hazard;
  logic        mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
  logic [31:0] fwd_a, fwd_b;

  // A store reads rs2 as data even though operand b is its immediate.
  always_comb begin
    hazard = valid_q & mr_q & (rd_q != '0) & id_valid &
             ((rd_q == id_rs1) | ((rd_q == id_rs2) & (~id_alu_src | id_mem_write)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      alu_src_q  <= 1'b0;
      alu_ctl_q  <= ALU_ADD;
      rw_q       <= 1'b0;
      mr_q       <= 1'b0;
      mw_q       <= 1'b0;
    end else if (flush || (!stall && hazard)) begin
      // Bubble: only the control bits are killed; operand regs hold.
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
    end else if (!stall) begin
      valid_q    <= id_valid;
      rs1_q      <= id_rs1;
      rs2_q      <= id_rs2;
      rd_q       <= id_rd;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
      alu_src_q  <= id_alu_src;
      alu_ctl_q  <= id_alu_control;
      rw_q       <= id_reg_write & id_valid;
      mr_q       <= id_mem_read & id_valid;
      mw_q       <= id_mem_write & id_valid;
    end
  end

  always_comb begin
    mem_hit_a = (FWD_EN != 0) && mem_reg_write && (mem_rd != '0) && (mem_rd == rs1_q);
    wb_hit_a  = (FWD_EN != 0) && wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs1_q);
    mem_hit_b = (FWD_EN != 0) && mem_reg_write && (mem_rd != '0) && (mem_rd == rs2_q);
    wb_hit_b  = (FWD_EN != 0) && wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs2_q);

    fwd_a = rs1_data_q;
    if (mem_hit_a)     fwd_a = mem_result;
    else if (wb_hit_a) fwd_a = wb_result;

    fwd_b = rs2_data_q;
    if (mem_hit_b)     fwd_b = mem_result;
    else if (wb_hit_b) fwd_b = wb_result;
  end

  assign ex_valid       = valid_q;
  assign ex_a           = fwd_a;
  assign ex_b           = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data  = fwd_b;
  assign ex_alu_control = alu_ctl_q;
  assign ex_rd          = rd_q;
  assign ex_reg_write   = rw_q & valid_q;
  assign ex_mem_read    = mr_q & valid_q;
  assign ex_mem_write   = mw_q & valid_q;
  assign load_use_stall = hazard;

endmodule

// File: tb/tb_id_ex_stage_g7.sv
// Scoreboard bench for id_ex_stage_g7: expected EX outputs are queued when
// stimulus is driven and popped when the stage presents them.
module tb_id_ex_stage_g7;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0101;

  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        lus;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_alu_src;
  logic [3:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        stall, flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;

  logic        v_f, rw_f, mr_f, mw_f, lus_f;
  logic [31:0] a_f, b_f, sd_f;
  logic [3:0]  ctl_f;
  logic [4:0]  rd_f;
  logic        v_n, rw_n, mr_n, mw_n, lus_n;
  logic [31:0] a_n, b_n, sd_n;
  logic [3:0]  ctl_n;
  logic [4:0]  rd_n;

  obs_t q[$];
  obs_t got, exp;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage_g7 #(.FWD_EN(1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_src(id_alu_src),
    .id_alu_control(id_alu_control), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(v_f), .ex_a(a_f), .ex_b(b_f), .ex_store_data(sd_f),
    .ex_alu_control(ctl_f), .ex_rd(rd_f), .ex_reg_write(rw_f),
    .ex_mem_read(mr_f), .ex_mem_write(mw_f), .load_use_stall(lus_f)
  );

  id_ex_stage_g7 #(.FWD_EN(0)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_src(id_alu_src),
    .id_alu_control(id_alu_control), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(v_n), .ex_a(a_n), .ex_b(b_n), .ex_store_data(sd_n),
    .ex_alu_control(ctl_n), .ex_rd(rd_n), .ex_reg_write(rw_n),
    .ex_mem_read(mr_n), .ex_mem_write(mw_n), .load_use_stall(lus_n)
  );

  function automatic obs_t obs_fwd();
    return {v_f, a_f, b_f, sd_f, ctl_f, rd_f, rw_f, mr_f, mw_f, lus_f};
  endfunction

  function automatic obs_t obs_nofwd();
    return {v_n, a_n, b_n, sd_n, ctl_n, rd_n, rw_n, mr_n, mw_n, lus_n};
  endfunction

  function automatic obs_t mk(input logic v, input logic [31:0] a, b, sd,
                              input logic [3:0] ctl, input logic [4:0] rd,
                              input logic rw, mr, mw, lus);
    return {v, a, b, sd, ctl, rd, rw, mr, mw, lus};
  endfunction

  task automatic drive_id(input logic v, input logic [4:0] rs1, rs2, rd,
                          input logic [31:0] d1, d2, imm, input logic src,
                          input logic [3:0] ctl, input logic rw, mr, mw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src;
    id_alu_control = ctl; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic clear_fwd();
    mem_rd = '0; mem_reg_write = 1'b0; mem_result = '0;
    wb_rd  = '0; wb_reg_write  = 1'b0; wb_result  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    clear_fwd();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, ALU_SUB, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    q.push_back(mk(0, '0, '0, '0, ALU_ADD, '0, 0, 0, 0, 0));
    q.push_back(mk(0, '0, '0, '0, ALU_ADD, '0, 0, 0, 0, 0));
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset got=%h exp=%h", got, exp); end
    exp = q.pop_front(); got = obs_nofwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_nofwd got=%h exp=%h", got, exp); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    @(negedge clk);
    drive_id(1, 5, 6, 9, 32'hAAAA0001, 32'hBBBB0002, 32'h0, 0, ALU_SUB, 1, 0, 0);
    q.push_back(mk(1, 32'hAAAA0001, 32'hBBBB0002, 32'hBBBB0002, ALU_SUB, 9, 1, 0, 0, 0));
    @(negedge clk);
    stall = 1'b1;
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fwd_capture got=%h exp=%h", got, exp); end

    mem_rd = 5; mem_reg_write = 1; mem_result = 32'h11;
    wb_rd  = 5; wb_reg_write  = 1; wb_result  = 32'h22;
    #1;
    q.push_back(mk(1, 32'h11, 32'hBBBB0002, 32'hBBBB0002, ALU_SUB, 9, 1, 0, 0, 0));
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fwd_mem_priority got=%h exp=%h", got, exp); end
    n_checks++;
    if (a_n !== 32'hAAAA0001) begin n_fail++; $display("FAIL nofwd_rs1 got=%h exp=%h", a_n, 32'hAAAA0001); end

    mem_reg_write = 0;
    #1;
    q.push_back(mk(1, 32'h22, 32'hBBBB0002, 32'hBBBB0002, ALU_SUB, 9, 1, 0, 0, 0));
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fwd_wb got=%h exp=%h", got, exp); end

    wb_rd = 6;
    #1;
    q.push_back(mk(1, 32'hAAAA0001, 32'h22, 32'h22, ALU_SUB, 9, 1, 0, 0, 0));
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fwd_rs2_wb got=%h exp=%h", got, exp); end

    wb_reg_write = 0;
    #1;
    q.push_back(mk(1, 32'hAAAA0001, 32'hBBBB0002, 32'hBBBB0002, ALU_SUB, 9, 1, 0, 0, 0));
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL fwd_none got=%h exp=%h", got, exp); end

    @(negedge clk);
    stall = 1'b0;
    drive_id(1, 0, 0, 3, 32'h12345678, 32'h9ABCDEF0, 32'h0, 0, ALU_OR, 1, 0, 0);
    mem_rd = 0; mem_reg_write = 1; mem_result = 32'h11;
    wb_rd  = 0; wb_reg_write  = 1; wb_result  = 32'h22;
    q.push_back(mk(1, 32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, ALU_OR, 3, 1, 0, 0, 0));
    @(negedge clk);
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL x0_not_fwd got=%h exp=%h", got, exp); end
    id_valid = 1'b0;
    clear_fwd();
  endtask

  task automatic test_alusrc();
    @(negedge clk);
    drive_id(1, 1, 3, 0, 32'h40, 32'h99, 32'hFFFFFFF0, 1, ALU_ADD, 0, 0, 1);
    q.push_back(mk(1, 32'h40, 32'hFFFFFFF0, 32'h99, ALU_ADD, 0, 0, 0, 1, 0));
    @(negedge clk);
    stall = 1'b1;
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL alusrc_capture got=%h exp=%h", got, exp); end
    mem_rd = 3; mem_reg_write = 1; mem_result = 32'h5;
    #1;
    q.push_back(mk(1, 32'h40, 32'hFFFFFFF0, 32'h5, ALU_ADD, 0, 0, 0, 1, 0));
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL alusrc_store_fwd got=%h exp=%h", got, exp); end
    clear_fwd();
    stall = 1'b0;
    id_valid = 1'b0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive_id(1, 2, 0, 7, 32'h100, 32'h0, 32'h4, 1, ALU_ADD, 1, 1, 0);
    q.push_back(mk(1, 32'h100, 32'h4, 32'h0, ALU_ADD, 7, 1, 1, 0, 1));
    @(negedge clk);
    drive_id(1, 7, 1, 8, 32'h7777, 32'h1111, 32'h0, 0, ALU_ADD, 1, 0, 0);
    #1;
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL lu_detect got=%h exp=%h", got, exp); end

    q.push_back(mk(0, 32'h100, 32'h4, 32'h0, ALU_ADD, 7, 0, 0, 0, 0));
    @(negedge clk);
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL lu_bubble got=%h exp=%h", got, exp); end

    q.push_back(mk(1, 32'hDEADBEEF, 32'h1111, 32'h1111, ALU_ADD, 8, 1, 0, 0, 0));
    @(negedge clk);
    wb_rd = 7; wb_reg_write = 1; wb_result = 32'hDEADBEEF;
    #1;
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL lu_add_wb_fwd got=%h exp=%h", got, exp); end
    id_valid = 1'b0;
    clear_fwd();

    @(negedge clk);
    drive_id(1, 2, 0, 7, 32'h100, 32'h0, 32'h4, 1, ALU_ADD, 1, 1, 0);
    @(negedge clk);
    stall = 1'b1;
    drive_id(1, 1, 7, 0, 32'h1, 32'h2, 32'h8, 1, ALU_ADD, 0, 0, 1);
    #1;
    n_checks++;
    if (lus_f !== 1'b1) begin n_fail++; $display("FAIL lu_store_rs2 got=%b exp=1", lus_f); end
    id_mem_write = 1'b0;
    #1;
    n_checks++;
    if (lus_f !== 1'b0) begin n_fail++; $display("FAIL lu_imm_rs2_ignored got=%b exp=0", lus_f); end
    id_valid = 1'b0;
    stall = 1'b0;
  endtask

  task automatic test_stall_flush();
    obs_t held;
    @(negedge clk);
    drive_id(1, 4, 5, 6, 32'h44, 32'h55, 32'h66, 0, ALU_AND, 1, 0, 0);
    held = mk(1, 32'h44, 32'h55, 32'h55, ALU_AND, 6, 1, 0, 0, 0);
    @(negedge clk);
    stall = 1'b1;
    drive_id(1, 9, 10, 11, 32'hA, 32'hB, 32'hC, 1, ALU_SRL, 1, 1, 1);
    for (int unsigned i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      q.push_back(held);
      exp = q.pop_front(); got = obs_fwd(); n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, exp); end
    end
    flush = 1'b1;
    q.push_back(mk(0, 32'h44, 32'h55, 32'h55, ALU_AND, 6, 0, 0, 0, 0));
    @(negedge clk);
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL stall_and_flush got=%h exp=%h", got, exp); end
    stall = 1'b0;
    q.push_back(mk(0, 32'h44, 32'h55, 32'h55, ALU_AND, 6, 0, 0, 0, 0));
    @(negedge clk);
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL flush_only got=%h exp=%h", got, exp); end
    flush = 1'b0;
    id_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_id(1, 3, 3, 12, 32'h33, 32'h34, 32'h0, 0, ALU_OR, 1, 0, 0);
    q.push_back(mk(1, 32'h33, 32'h34, 32'h34, ALU_OR, 12, 1, 0, 0, 0));
    @(negedge clk);
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL pre_reset got=%h exp=%h", got, exp); end
    #2 rst_n = 1'b0;
    #1;
    q.push_back(mk(0, '0, '0, '0, ALU_ADD, '0, 0, 0, 0, 0));
    q.push_back(mk(0, '0, '0, '0, ALU_ADD, '0, 0, 0, 0, 0));
    exp = q.pop_front(); got = obs_fwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL async_reset got=%h exp=%h", got, exp); end
    exp = q.pop_front(); got = obs_nofwd(); n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL async_reset_nofwd got=%h exp=%h", got, exp); end
    @(negedge clk);
    rst_n = 1'b1;
    id_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_alusrc();
    test_load_use();
    test_stall_flush();
    test_reset_mid();
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got=%0d exp=0", q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
